// File: rtl/word_packer.sv
// Packs a stream of IN_W-bit lanes into RATIO-lane words with selectable lane order,
// output ready/valid backpressure, partial-word flush and sticky overrun detection.
module word_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CW       = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             dval,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             flush_pend_q, flush_pend_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             out_free;
    logic [OUT_W-1:0] acc_ins;
    logic [CW-1:0]    c_eff;
    logic             load;
    logic [OUT_W-1:0] load_data;
    logic [CW-1:0]    load_count;

    // in_ready depends only on registered state, so no input reaches it combinationally.
    assign in_ready  = (state_q == S_FILL);
    assign accept    = dval && in_ready;
    assign out_free  = !out_valid_q || out_ready;
    assign c_eff     = accept ? count_q + CW'(1) : count_q;

    assign data_out  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign overrun   = overrun_q;

    // Accumulator with the incoming lane dropped into slot count_q.
    always_comb begin
        acc_ins = acc_q;
        if (accept) begin
            for (int i = 0; i < RATIO; i++) begin
                if (count_q == CW'(i)) begin
                    acc_ins[(MSB_FIRST ? (RATIO - 1 - i) * IN_W : i * IN_W) +: IN_W] = data_in;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        load_data    = acc_ins;
        load_count   = c_eff;

        case (state_q)
            S_FILL: begin
                // A completed word and a non-empty flush share the same emit path.
                if ((accept && count_q == CW'(RATIO - 1)) || (flush && c_eff != '0)) begin
                    if (out_free) begin
                        load    = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        acc_d        = acc_ins;
                        count_d      = c_eff;
                        flush_pend_d = (c_eff != CW'(RATIO));
                        state_d      = S_HOLD;
                    end
                end else if (accept) begin
                    acc_d   = acc_ins;
                    count_d = c_eff;
                end
            end
            S_HOLD: begin
                load_data  = acc_q;
                load_count = flush_pend_q ? count_q : CW'(RATIO);
                if (out_free) begin
                    load         = 1'b1;
                    acc_d        = '0;
                    count_d      = '0;
                    flush_pend_d = 1'b0;
                    state_d      = S_FILL;
                end
            end
            default: begin
                state_d      = S_FILL;
                acc_d        = '0;
                count_d      = '0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = load_data;
            out_count_d = load_count;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Setting wins over clearing when both happen in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (dval && !in_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            acc_q        <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: one MSB-first and one LSB-first instance share stimulus.
module tb_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        dval;
    logic        flush;
    logic        out_ready;
    logic        clr_overrun;

    logic        m_in_ready, l_in_ready;
    logic [31:0] m_data, l_data;
    logic        m_valid, l_valid;
    logic [2:0]  m_count, l_count;
    logic        m_ovr, l_ovr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .dval(dval), .in_ready(m_in_ready),
        .flush(flush), .data_out(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .out_count(m_count), .overrun(m_ovr), .clr_overrun(clr_overrun)
    );

    word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .dval(dval), .in_ready(l_in_ready),
        .flush(flush), .data_out(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .out_count(l_count), .overrun(l_ovr), .clr_overrun(clr_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input logic [7:0] b);
        dval    = 1'b1;
        data_in = b;
        tick();
        dval    = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] m_exp, input logic [31:0] l_exp,
                            input logic [2:0] cnt);
        chk({tag, "_valid_m"}, 64'(m_valid), 64'(1));
        chk({tag, "_valid_l"}, 64'(l_valid), 64'(1));
        chk({tag, "_data_m"},  64'(m_data), 64'(m_exp));
        chk({tag, "_data_l"},  64'(l_data), 64'(l_exp));
        chk({tag, "_count_m"}, 64'(m_count), 64'(cnt));
        chk({tag, "_count_l"}, 64'(l_count), 64'(cnt));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},   64'({m_valid, l_valid}), 64'(0));
        chk({tag, "_data"},    64'({m_data, l_data}), 64'(0));
        chk({tag, "_count"},   64'({m_count, l_count}), 64'(0));
        chk({tag, "_overrun"}, 64'({m_ovr, l_ovr}), 64'(0));
        chk({tag, "_in_ready"}, 64'({m_in_ready, l_in_ready}), 64'(3));
    endtask

    initial begin
        rst = 1'b1; data_in = '0; dval = 1'b0; flush = 1'b0;
        out_ready = 1'b1; clr_overrun = 1'b0;
        tick();
        dval = 1'b1; data_in = 8'hEE; flush = 1'b1;
        tick();
        dval = 1'b0; flush = 1'b0;
        chk_reset("reset");
        rst = 1'b0;

        // Full words in both lane orders, then back-to-back streaming.
        lane(8'h12); lane(8'h34); lane(8'h56); lane(8'h78);
        chk_word("w1", 32'h12345678, 32'h78563412, 3'd4);
        tick();
        chk("w1_drained", 64'({m_valid, l_valid}), 64'(0));

        lane(8'hAB); lane(8'hCD); lane(8'hEF); lane(8'h01);
        chk_word("w2", 32'hABCDEF01, 32'h01EFCDAB, 3'd4);
        lane(8'hA0);
        chk("stream_in_ready", 64'({m_in_ready, l_in_ready}), 64'(3));
        lane(8'hA1); lane(8'hA2); lane(8'hA3);
        chk_word("w3", 32'hA0A1A2A3, 32'hA3A2A1A0, 3'd4);
        tick();

        // Partial flush, then flush with an empty accumulator.
        lane(8'h11); lane(8'h22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_word("flush2", 32'h11220000, 32'h00002211, 3'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush", 64'({m_valid, l_valid}), 64'(0));

        // Backpressure: second word completes into HOLD.
        out_ready = 1'b0;
        lane(8'h01); lane(8'h02); lane(8'h03); lane(8'h04);
        chk_word("bp_w1", 32'h01020304, 32'h04030201, 3'd4);
        lane(8'h05); lane(8'h06); lane(8'h07); lane(8'h08);
        chk("bp_in_ready", 64'({m_in_ready, l_in_ready}), 64'(0));
        chk_word("bp_w1_stable", 32'h01020304, 32'h04030201, 3'd4);

        // Overrun while stalled: set, clear, set-and-clear together.
        lane(8'hFF);
        chk("ovr_set", 64'({m_ovr, l_ovr}), 64'(3));
        clr_overrun = 1'b1;
        tick();
        chk("ovr_clr", 64'({m_ovr, l_ovr}), 64'(0));
        lane(8'hFF);
        clr_overrun = 1'b0;
        chk("ovr_set_wins", 64'({m_ovr, l_ovr}), 64'(3));
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr2", 64'({m_ovr, l_ovr}), 64'(0));

        out_ready = 1'b1;
        chk_word("bp_w1_offer", 32'h01020304, 32'h04030201, 3'd4);
        tick();
        chk_word("bp_w2", 32'h05060708, 32'h08070605, 3'd4);
        chk("hold_exit_in_ready", 64'({m_in_ready, l_in_ready}), 64'(3));
        tick();
        chk("bp_drained", 64'({m_valid, l_valid}), 64'(0));

        // Reset mid-word discards the partial lanes.
        lane(8'h0A); lane(8'h0B); lane(8'h0C);
        rst = 1'b1; dval = 1'b1; data_in = 8'h0D;
        tick();
        rst = 1'b0; dval = 1'b0;
        chk_reset("mid_reset");
        lane(8'h21); lane(8'h22); lane(8'h23); lane(8'h24);
        chk_word("post_reset", 32'h21222324, 32'h24232221, 3'd4);
        tick();

        // Flush with a same-edge lane while the output register is full.
        out_ready = 1'b0;
        lane(8'h41); lane(8'h42); lane(8'h43); lane(8'h44);
        lane(8'h51);
        flush = 1'b1;
        lane(8'h52);
        flush = 1'b0;
        chk("pend_in_ready", 64'({m_in_ready, l_in_ready}), 64'(0));
        chk_word("pend_held", 32'h41424344, 32'h44434241, 3'd4);
        out_ready = 1'b1;
        tick();
        chk_word("pend_flush", 32'h51520000, 32'h00005251, 3'd2);
        chk("pend_in_ready2", 64'({m_in_ready, l_in_ready}), 64'(3));
        tick();
        chk("pend_drained", 64'({m_valid, l_valid}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_packer.md
# word_packer

Parametrised successor to the byte-to-word buffer filler in the host-interface path. Packs a stream of IN_W-bit lanes into RATIO-lane output words with selectable lane order. Adds an output ready/valid handshake with backpressure, input flow control, partial-word flush, and sticky overrun detection. Sits between the serial/byte receiver and the instruction/data memory loader.

## Interface
- IN_W, 8, input lane width in bits (>=1)
- RATIO, 4, lanes per output word (>=2); OUT_W = IN_W*RATIO
- MSB_FIRST, 1, 1: first lane lands in data_out[OUT_W-1 -: IN_W]; 0: first lane lands in data_out[IN_W-1:0]
- CW = $clog2(RATIO+1), count width (derived localparam)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  IN_W  input lane
- dval  in  1  lane valid; accepted on an edge where dval && in_ready
- in_ready  out  1  accumulator can take a lane this cycle
- flush  in  1  emit the current partial word (level request)
- data_out  out  OUT_W  packed word; stable while out_valid && !out_ready
- out_valid  out  1  data_out/out_count valid
- out_ready  in  1  consumer accepts; transfer on out_valid && out_ready
- out_count  out  CW  valid lanes in data_out (RATIO for full words, 1..RATIO-1 for flushed)
- overrun  out  1  sticky: dval seen while in_ready low
- clr_overrun  in  1  clears overrun (set wins if both in the same cycle)

## Operation
- Storage: accumulator (RATIO lanes + count 0..RATIO) and one output register (data_out, out_count, out_valid).
- States: FILL (count<RATIO, no flush pending), HOLD (accumulator complete or flush pending, waiting for the output register).
- out_free = !out_valid || out_ready (same-cycle drain counts as free).
- Lane placement: lane k (k = arrival order from 0) goes to bits [OUT_W-1-k*IN_W -: IN_W] if MSB_FIRST, else [k*IN_W +: IN_W]. Unfilled lanes read 0.
- FILL, accepted lane, count==RATIO-1: the word completes. If out_free, load the output register the same edge (out_count=RATIO) and set count=0. Otherwise store the lane, set count=RATIO, go to HOLD.
- FILL, accepted lane, count<RATIO-1: store the lane and increment count.
- Flush in FILL with effective count c>0 (c includes a lane accepted the same edge): if c==RATIO, treat as a normal complete word. Else if out_free, load a partial word (out_count=c), count=0. Else latch flush_pending and go to HOLD.
- Flush with c==0 is a no-op; it never produces a zero-lane word.
- HOLD: in_ready=0. When out_free, load the accumulator contents into the output register (out_count=count, or RATIO if complete), clear count and flush_pending, return to FILL.
- in_ready = (state==FILL), combinational from registered state only; no input-to-output combinational path.
- Output register: out_valid clears on transfer unless reloaded the same edge. Back-to-back words therefore stream at one word per RATIO lanes with no bubble.
- Overrun: dval && !in_ready sets overrun; the lane is dropped and the accumulator is unchanged.
- Reset: while rst is high at an edge, all state clears; dval, flush and out_ready are ignored that cycle.

## Timing
- Reset values: data_out=0, out_valid=0, out_count=0, overrun=0, in_ready=1 (FILL, count=0), flush_pending=0.
- Latency: the last lane accepted at edge N gives out_valid=1 from edge N, visible in cycle N+1.
- Flush asserted at edge N with out_free gives a partial word visible in cycle N+1.
- HOLD exit: out_ready high at edge M loads the held word at edge M. in_ready=1 in cycle M+1.
- Throughput: one lane per cycle sustained when out_ready is held high.
- Reset mid-word discards partial lanes and any held or output word, with no output transfer.

## Test plan
- Reset, then lanes 12,34,56,78 on consecutive cycles with out_ready=1, MSB_FIRST=1 -> one cycle after the 4th lane: out_valid=1, data_out=32'h12345678, out_count=4.
- MSB_FIRST=0, lanes AB,CD,EF,01 -> data_out=32'h01EFCDAB, out_count=4.
- Lanes 11,22 then flush -> data_out=32'h11220000, out_count=2. A flush with an empty accumulator produces no output.
- out_ready=0, send 8 lanes 01..08 -> first word 32'h01020304 held and stable. After lane 08, in_ready=0. Raise out_ready -> 32'h01020304 then 32'h05060708, no lane lost.
- While in_ready=0, drive dval with lane FF -> overrun=1 and FF absent from output. clr_overrun -> overrun=0. Set and clear in the same cycle -> stays 1.
- Assert rst after 3 lanes of a word -> all outputs at reset values. The next 4 lanes form a clean word with no residue from before the reset.
